// File: rtl/iterative_divider_if.sv
// Request/response bundle between the core and the iterative divider.
// The master issues divide requests and the slave returns results.
interface iterative_divider_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one shift-subtract per cycle on
// operand magnitudes, then one cycle of sign correction before the done pulse.
module iterative_divider #(
    parameter int unsigned N = 32
) (
    input  logic              clk,
    input  logic              rst,
    iterative_divider_if.slave dif
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic [N-1:0]  q, q_nx;
    logic [N-1:0]  rem, rem_nx;
    logic [N-1:0]  dvs, dvs_nx;
    logic [N-1:0]  a_org, a_org_nx;
    logic [N-1:0]  result, result_nx;
    logic          sa, sa_nx;
    logic          sb, sb_nx;
    logic          is_rem, is_rem_nx;
    logic          div0, div0_nx;
    logic          busy, busy_nx;
    logic          done, done_nx;

    logic [N:0]    shifted;
    logic          fits;
    logic [N-1:0]  quot_fix;
    logic [N-1:0]  rem_fix;

    // One restoring step: the N+1-bit partial remainder is compared against |b|.
    always_comb begin
        shifted = {rem, q[N-1]};
        fits    = (shifted >= {1'b0, dvs});
    end

    // Divide-by-zero bypasses sign correction and reports the raw dividend.
    always_comb begin
        quot_fix = div0 ? '1    : ((sa ^ sb) ? (-q) : q);
        rem_fix  = div0 ? a_org : (sa ? (-rem) : rem);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            q      <= '0;
            rem    <= '0;
            dvs    <= '0;
            a_org  <= '0;
            result <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            is_rem <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            q      <= q_nx;
            rem    <= rem_nx;
            dvs    <= dvs_nx;
            a_org  <= a_org_nx;
            result <= result_nx;
            sa     <= sa_nx;
            sb     <= sb_nx;
            is_rem <= is_rem_nx;
            div0   <= div0_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        q_nx      = q;
        rem_nx    = rem;
        dvs_nx    = dvs;
        a_org_nx  = a_org;
        result_nx = result;
        sa_nx     = sa;
        sb_nx     = sb;
        is_rem_nx = is_rem;
        div0_nx   = div0;
        busy_nx   = busy;
        done_nx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (dif.start) begin
                    sa_nx     = dif.a[N-1] & ~dif.op[0];
                    sb_nx     = dif.b[N-1] & ~dif.op[0];
                    q_nx      = sa_nx ? (-dif.a) : dif.a;
                    dvs_nx    = sb_nx ? (-dif.b) : dif.b;
                    a_org_nx  = dif.a;
                    is_rem_nx = dif.op[1];
                    div0_nx   = (dif.b == '0);
                    rem_nx    = '0;
                    count_nx  = '0;
                    busy_nx   = 1'b1;
                    state_nx  = CALC;
                end
            end
            CALC: begin
                // Counts 0..N-1 iterate; count N is the sign-correction cycle.
                if (count == CW'(N)) begin
                    result_nx = is_rem ? rem_fix : quot_fix;
                    done_nx   = 1'b1;
                    state_nx  = DONE;
                end else begin
                    q_nx     = {q[N-2:0], fits};
                    rem_nx   = fits ? (shifted[N-1:0] - dvs) : shifted[N-1:0];
                    count_nx = count + CW'(1);
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign dif.busy   = busy;
    assign dif.done   = done;
    assign dif.result = result;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed vectors, held-start, reset abort,
// back-to-back issue and a reference-model sweep.
module tb_iterative_divider;

    localparam int unsigned N = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam logic [N-1:0] INT_MIN = 32'h8000_0000;

    typedef struct {
        logic [N-1:0] res;
        int unsigned  cyc;
        int           id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    exp_t e_mon;

    iterative_divider_if #(.N(N)) dif ();

    iterative_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        if (!rst && dif.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e_mon = sb.pop_front();
                check($sformatf("op%0d_result", e_mon.id), dif.result, e_mon.res);
                n_cmp++;
                if (cyc != e_mon.cyc) begin
                    n_bad++;
                    $display("FAIL op%0d_latency: got done at cycle %0d expected cycle %0d",
                             e_mon.id, cyc, e_mon.cyc);
                end
                check($sformatf("op%0d_busy_at_done", e_mon.id), N'(dif.busy), N'(1));
            end
        end
    end

    function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic signed [N-1:0] sa_v;
        logic signed [N-1:0] sb_v;
        logic [N-1:0] r;
        sa_v = a;
        sb_v = b;
        case (op)
            OP_DIV:  r = (b == '0) ? '1 : ((a == INT_MIN && b == '1) ? INT_MIN : N'(sa_v / sb_v));
            OP_DIVU: r = (b == '0) ? '1 : a / b;
            OP_REM:  r = (b == '0) ? a  : ((a == INT_MIN && b == '1) ? '0 : N'(sa_v % sb_v));
            default: r = (b == '0) ? a  : a % b;
        endcase
        return r;
    endfunction

    // Accept edge follows this negedge; done is expected N+2 cycles later.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input int id);
        exp_t e;
        @(negedge clk);
        dif.start = 1'b1;
        dif.op    = op;
        dif.a     = a;
        dif.b     = b;
        e.res = exp;
        e.cyc = cyc + N + 2;
        e.id  = id;
        sb.push_back(e);
        @(negedge clk);
        dif.start = 1'b0;
        dif.a     = $urandom;
        dif.b     = $urandom;
        dif.op    = 2'($urandom);
    endtask

    task automatic wait_idle();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < int'(N) + 10; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] exp, input int id);
        issue(op, a, b, exp, id);
        wait_idle();
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [N-1:0] r_a;
        logic [N-1:0] r_b;
        exp_t e;

        dif.start = 1'b0;
        dif.op    = 2'b00;
        dif.a     = '0;
        dif.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy",   N'(dif.busy), '0);
        check("reset_done",   N'(dif.done), '0);
        check("reset_result", dif.result,   '0);
        rst = 1'b0;

        // Directed vectors
        run(OP_DIVU, 32'd100,      32'd7,        32'd14,        1);
        run(OP_REMU, 32'd100,      32'd7,        32'd2,         2);
        run(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  3);
        run(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  4);
        run(OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF,  5);
        run(OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB,  6);
        run(OP_DIV,  INT_MIN,      32'hFFFFFFFF, INT_MIN,       7);
        run(OP_REM,  INT_MIN,      32'hFFFFFFFF, 32'd0,         8);
        run(OP_DIVU, INT_MIN,      32'hFFFFFFFF, 32'd0,         9);
        run(OP_REMU, INT_MIN,      32'hFFFFFFFF, INT_MIN,      10);
        run(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 11);
        run(OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        12);
        run(OP_DIV,  INT_MIN,      32'd2,        32'hC0000000, 13);
        run(OP_REMU, 32'd123,      32'd0,        32'd123,      14);
        run(OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 15);

        // Start held high through CALC and DONE, operands scrambled mid-flight
        @(negedge clk);
        dif.start = 1'b1;
        dif.op    = OP_DIV;
        dif.a     = 32'hFFFFFF9C;
        dif.b     = 32'd7;
        e.res = 32'hFFFFFFF2;
        e.cyc = cyc + N + 2;
        e.id  = 16;
        sb.push_back(e);
        for (int i = 0; i < int'(N) + 3; i++) begin
            @(negedge clk);
            dif.a  = $urandom;
            dif.b  = $urandom;
            dif.op = 2'($urandom);
        end
        dif.start = 1'b0;
        repeat (N + 5) @(negedge clk);
        check("held_start_no_reaccept", N'(dif.busy), '0);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL held_start_done: got %0d results outstanding expected 0", sb.size());
            sb.delete();
        end

        // Back-to-back: each issue lands in the idle cycle right after done
        run(OP_DIVU, 32'd1000, 32'd10, 32'd100, 17);
        run(OP_REM,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 18);
        run(OP_DIV,  32'd45, 32'hFFFFFFFB, 32'hFFFFFFF7, 19);

        // Reset mid-CALC aborts without a done
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd333, 20);
        repeat (9) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        #1;
        check("abort_busy",   N'(dif.busy), '0);
        check("abort_done",   N'(dif.done), '0);
        check("abort_result", dif.result,   '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(OP_REMU, 32'd1000, 32'd3, 32'd1, 21);

        // Reference-model sweep with edge operands mixed in
        for (int i = 0; i < 48; i++) begin
            r_op = 2'($urandom);
            case ($urandom_range(0, 5))
                0:       r_a = INT_MIN;
                1:       r_a = '0;
                2:       r_a = 32'($urandom_range(0, 200));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       r_b = '0;
                1:       r_b = 32'd1;
                2:       r_b = '1;
                3:       r_b = 32'($urandom_range(1, 20));
                4:       r_b = -32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            run(r_op, r_a, r_b, model(r_op, r_a, r_b), 100 + i);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
